uart_text_loader: RTL and testbench
===================================

Name: uart_text_loader

Overview:
- Host-side input path for the text processor. Receives a NUL-terminated text string over an 8N1 UART line and packs the bytes little-endian into 32-bit words.
- Writes those words into DATA_RAM through the same write port the CPU uses (mem_we / mem_addr / mem_wdata). It holds the CPU off the bus while loading.
- When the string is complete, it pulses the CPU start input.
- It is the writer side of the text buffer that the CPU later reads.

Parameters:
CLK_FREQ, 50_000_000, clk frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (434 at defaults)
BASE_ADDR, 32'h0000_0000, byte address of the first word written
MAX_WORDS, 256, buffer capacity in words

Ports:
clk  in  1  system clock, single domain
reset  in  1  synchronous, active-high
rx  in  1  UART serial input, idle high, asynchronous to clk
mem_we  out  1  one-cycle write strobe to DATA_RAM
mem_addr  out  32  byte address, word aligned
mem_wdata  out  32  packed word
cpu_hold  out  1  high while a frame is being loaded; CPU must not drive the RAM port
start_pulse  out  1  one-cycle pulse to the CPU start input when loading completes
frame_err  out  1  sticky: a byte had a low stop bit
overflow  out  1  sticky: MAX_WORDS filled before the terminator arrived

Behaviour:
- Reset state:
  - All outputs 0.
  - word_idx and byte_idx = 0.
  - RX FSM in IDLE; synchronizer flops set to 1.
  - Reset mid-frame abandons the frame; no start_pulse is issued.
- rx synchronization:
  - rx passes through a 2-FF synchronizer; all RX decisions use the synchronized value.
- RX FSM (IDLE, START, DATA, STOP), with a baud counter 0..CLKS_PER_BIT-1:
  - IDLE -> START on sync_rx == 0.
  - START: after CLKS_PER_BIT/2 cycles, resample. If 0, go to DATA; if 1, treat as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: byte_valid pulses for one cycle with the byte.
    - If 0: set frame_err and discard the byte.
    - Either way, return to IDLE.
- Loader FSM (COLLECT, WRITE, DONE):
  - COLLECT, on byte_valid:
    - Shift the byte into lane byte_idx; the first byte goes to bits [7:0].
    - cpu_hold = 1 from this cycle on.
    - byte_idx increments.
  - COLLECT -> WRITE when the 4th byte of a word lands, or when the byte is 0x00. The terminator is stored, and unused upper lanes are zero.
  - WRITE, exactly one cycle:
    - mem_we = 1, mem_addr = BASE_ADDR + 4*word_idx, mem_wdata = packed word.
    - word_idx increments and byte_idx clears.
    - Next state is DONE if the word held the terminator, or if word_idx was MAX_WORDS-1 (that case also sets overflow). Otherwise back to COLLECT.
  - DONE, one cycle:
    - start_pulse = 1 and cpu_hold = 0.
    - word_idx clears; return to COLLECT ready for a new frame.
- Latency: the write strobe occurs 1 cycle after the byte_valid that completes the word; start_pulse follows 1 cycle later.
- A byte arriving during WRITE or DONE cannot collide with either state: bytes are ≥ 10*CLKS_PER_BIT apart.
- A lone 0x00 frame writes one word 0x0000_0000 at BASE_ADDR, then pulses start.
- frame_err and overflow clear only on reset.

Decomposition:
- Shared package arm_const gains:
  - TEXT_BASE_ADDR and TEXT_MAX_WORDS, used as the defaults.
  - typedef enum rx_state_t {IDLE, START, DATA, STOP}.
  - typedef enum ld_state_t {COLLECT, WRITE, DONE}.
- One sub-module, uart_rx: synchronizer plus RX FSM. Outputs byte_valid, byte[7:0] and stop_err.
- uart_text_loader instantiates uart_rx and contains the packing FSM.

Test Plan:
- Send "Hi!" + 0x00 -> one write of 32'h0021_6948 at 0x0. start_pulse is high exactly 1 cycle, 2 cycles after the final stop-bit sample. cpu_hold is high from the first byte until the start_pulse cycle.
- Send "ABCDE" + 0x00 -> writes 32'h4443_4241 @0x0 and 32'h0000_0045 @0x4, then start_pulse.
- Send a byte with stop bit driven 0, then "A" + 0x00 -> frame_err = 1. The bad byte is dropped; the single write is 32'h0000_0041 @0x0.
- MAX_WORDS=2, send 9 non-zero bytes -> writes @0x0 and @0x4, overflow = 1, start_pulse once. The 9th byte begins a new frame at 0x0.
- 0.3-bit-wide low glitch on rx, then idle -> no byte_valid, no write, all outputs stay 0.
- Assert reset after 2 bytes of a frame, then send "Z" + 0x00 -> no pulse before reset. Single write 32'h0000_005A @0x0, then start_pulse.

Source files
------------

// File: rtl/arm_const.sv
// rtl/arm_const.sv - shared constants and state types for the text loader path
package arm_const;

    localparam logic [31:0] TEXT_BASE_ADDR = 32'h0000_0000;
    localparam int          TEXT_MAX_WORDS = 256;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {COLLECT, WRITE, DONE} ld_state_t;

endpackage

// File: rtl/uart_text_loader_rx.sv
// rtl/uart_text_loader_rx.sv - 8N1 UART receiver with 2-FF input synchronizer
module uart_rx
    import arm_const::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    logic             rx_meta;
    logic             sync_rx;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            sync_rx    <= 1'b1;
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            stop_err   <= 1'b0;
        end else begin
            rx_meta    <= rx;
            sync_rx    <= rx_meta;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!sync_rx) state <= START;
                end
                START: begin
                    // Mid-bit recheck rejects short low glitches
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= sync_rx ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {sync_rx, shreg[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (sync_rx) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            stop_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_text_loader.sv
// rtl/uart_text_loader.sv - packs a NUL-terminated UART string into DATA_RAM words
module uart_text_loader
    import arm_const::*;
#(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = TEXT_BASE_ADDR,
    parameter int          MAX_WORDS = TEXT_MAX_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        start_pulse,
    output logic        frame_err,
    output logic        overflow
);

    localparam int WIDX_W = $clog2(MAX_WORDS) + 1;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              stop_err;
    ld_state_t         state;
    logic [WIDX_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       word_buf;
    logic              term;
    logic              hold_r;

    uart_rx #(
        .CLKS_PER_BIT(CLK_FREQ / BAUD)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .stop_err  (stop_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            word_idx  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            term      <= 1'b0;
            hold_r    <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (stop_err) frame_err <= 1'b1;
            case (state)
                COLLECT: begin
                    if (byte_valid) begin
                        hold_r <= 1'b1;
                        word_buf[{byte_idx, 3'b000} +: 8] <= byte_data;
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_data == 8'h00 || byte_idx == 2'd3) begin
                            state <= WRITE;
                            term  <= (byte_data == 8'h00);
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    byte_idx <= '0;
                    // Cleared so lanes above a terminator read back as zero
                    word_buf <= '0;
                    term     <= 1'b0;
                    if (term) begin
                        state <= DONE;
                    end else if (word_idx == WIDX_W'(MAX_WORDS - 1)) begin
                        overflow <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= COLLECT;
                    end
                end
                DONE: begin
                    hold_r   <= 1'b0;
                    word_idx <= '0;
                    state    <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign mem_we      = (state == WRITE);
    assign mem_addr    = BASE_ADDR + (32'(word_idx) << 2);
    assign mem_wdata   = word_buf;
    assign start_pulse = (state == DONE);
    assign cpu_hold    = (state != DONE) && (hold_r || (state == COLLECT && byte_valid));

endmodule

// File: tb/tb_uart_text_loader.sv
// tb/tb_uart_text_loader.sv - scoreboard bench for uart_text_loader
module tb_uart_text_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        start_pulse;
    logic        frame_err;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] wq[$];
    int          pending_starts = 0;
    logic        prev_we = 1'b0;

    uart_text_loader #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000),
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .start_pulse(start_pulse),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h, none expected", mem_addr, mem_wdata);
                end else begin
                    logic [63:0] exp;
                    exp = wq.pop_front();
                    if ({mem_addr, mem_wdata} !== exp || cpu_hold !== 1'b1) begin
                        errors++;
                        $display("FAIL write: got addr=%h data=%h hold=%b, expected addr=%h data=%h hold=1",
                                 mem_addr, mem_wdata, cpu_hold, exp[63:32], exp[31:0]);
                    end
                end
            end
            if (start_pulse) begin
                checks++;
                if (pending_starts == 0 || prev_we !== 1'b1 || cpu_hold !== 1'b0) begin
                    errors++;
                    $display("FAIL start_pulse: pending=%0d prev_we=%b hold=%b, expected pending>0 prev_we=1 hold=0",
                             pending_starts, prev_we, cpu_hold);
                end
                if (pending_starts > 0) pending_starts--;
            end
            prev_we = mem_we;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        if (good_stop) drive(1'b1, CPB);
        else drive(1'b0, (CPB * 3) / 4);
        drive(1'b1, 2 * CPB);
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        wq.push_back({a, d});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && (wq.size() != 0 || pending_starts != 0); i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("drain_writes", 32'(wq.size()), 32'd0);
        chk("drain_starts", 32'(pending_starts), 32'd0);
        wq.delete();
        pending_starts = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_start", 32'(start_pulse), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        push_write(32'h0, 32'h0021_6948);
        pending_starts++;
        send_byte(8'h48, 1'b1);
        chk("hi_hold_after_first", 32'(cpu_hold), 32'd1);
        send_byte(8'h69, 1'b1);
        send_byte(8'h21, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_drain();
        chk("hi_hold_released", 32'(cpu_hold), 32'd0);

        push_write(32'h0, 32'h4443_4241);
        push_write(32'h4, 32'h0000_0045);
        pending_starts++;
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_drain();
        chk("abcde_overflow", 32'(overflow), 32'd0);

        send_byte(8'h55, 1'b0);
        chk("bad_stop_frame_err", 32'(frame_err), 32'd1);
        chk("bad_stop_no_hold", 32'(cpu_hold), 32'd0);
        push_write(32'h0, 32'h0000_0041);
        pending_starts++;
        send_byte(8'h41, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_drain();
        chk("frame_err_sticky", 32'(frame_err), 32'd1);

        do_reset();
        chk("frame_err_cleared", 32'(frame_err), 32'd0);

        drive(1'b0, 5);
        drive(1'b1, 10 * CPB);
        chk("glitch_hold", 32'(cpu_hold), 32'd0);
        chk("glitch_frame_err", 32'(frame_err), 32'd0);
        chk("glitch_overflow", 32'(overflow), 32'd0);
        chk("glitch_we", 32'(mem_we), 32'd0);

        push_write(32'h0, 32'h3433_3231);
        push_write(32'h4, 32'h3837_3635);
        pending_starts++;
        for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), 1'b1);
        wait_drain();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_new_frame_hold", 32'(cpu_hold), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);
        chk("ovf_hold_cleared", 32'(cpu_hold), 32'd0);

        send_byte(8'h58, 1'b1);
        send_byte(8'h59, 1'b1);
        chk("mid_reset_hold", 32'(cpu_hold), 32'd1);
        do_reset();
        chk("mid_reset_hold_cleared", 32'(cpu_hold), 32'd0);
        push_write(32'h0, 32'h0000_005A);
        pending_starts++;
        send_byte(8'h5A, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
